// File: rtl/disp_pkg.sv
// Shared constants for the 7-segment display scanner.
package disp_pkg;

    // Largest digit count the scanner supports.
    localparam int unsigned NdigMax = 12;

    // Field positions within disp_ctrl.
    localparam int unsigned CtrlLLsb = 0;  // [1:0] low-half source
    localparam int unsigned CtrlHLsb = 2;  // [3:2] high-half 16-bit page

    // Sources for the low 32 bits of the composed word.
    typedef enum logic [1:0] {
        LSrcMid  = 2'd0,  // disp_reg[127:96]
        LSrcLow  = 2'd1,  // disp_reg[95:64]
        LSrcTop  = 2'd2,  // disp_reg[159:128]
        LSrcZero = 2'd3   // constant zero
    } l_src_e;

    // Active-low hex decode {dp,g,f,e,d,c,b,a} with dp off; entry n at index n.
    localparam logic [15:0][7:0] SegLut = {
        8'h8E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80,
        8'hF8, 8'h82, 8'h92, 8'h99, 8'hB0, 8'hA4, 8'hF9, 8'hC0
    };

endpackage

// File: rtl/seg7_dec.sv
// Combinational nibble + decimal point to active-low segment pattern.
module seg7_dec (
    input  logic [3:0] nib_i,
    input  logic       dp_i,
    output logic [7:0] seg_o
);
    import disp_pkg::*;

    // Look up the glyph and overlay the active-low decimal point.
    always_comb begin
        seg_o = {~dp_i, SegLut[nib_i][6:0]};
    end

endmodule

// File: rtl/disp_scan_mux.sv
// Time-multiplexed 7-segment scanner: frame snapshot, leading-zero blanking,
// dead-time blanking at each digit change and per-slot brightness PWM.
module disp_scan_mux #(
    parameter int unsigned NDIG  = 12,
    parameter int unsigned DIV_W = 9,
    parameter int unsigned DEAD  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [159:0]      disp_reg,
    input  logic [3:0]        disp_ctrl,
    input  logic [NDIG-1:0]   dp_mask,
    input  logic              blank_lz,
    input  logic [3:0]        bright,
    output logic [NDIG-1:0]   digit_anode,
    output logic [7:0]        segment,
    output logic              frame_start
);
    import disp_pkg::*;

    localparam int unsigned IdxW = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam int unsigned WordW = 4 * NDIG;
    localparam logic [DIV_W-1:0] DeadCnt = DIV_W'(DEAD);
    localparam logic [IdxW-1:0] IdxLast = IdxW'(NDIG - 1);

    if (NDIG < 1 || NDIG > NdigMax) begin : gen_bad_ndig
        $error("disp_scan_mux: NDIG out of range");
    end
    if (DIV_W < 5) begin : gen_bad_div
        $error("disp_scan_mux: DIV_W must be at least 5");
    end
    if (DEAD < 1 || DEAD >= (1 << (DIV_W - 4))) begin : gen_bad_dead
        $error("disp_scan_mux: DEAD out of range");
    end

    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [IdxW-1:0]  idx_q, idx_d;
    logic [WordW-1:0] snap_w_q, snap_w_d;
    logic [NDIG-1:0]  snap_dp_q, snap_dp_d;
    logic             snap_lz_q, snap_lz_d;
    logic             load_pend_q, load_pend_d;
    logic [NDIG-1:0]  anode_q, anode_d;
    logic [7:0]       seg_q, seg_d;
    logic             frame_start_q, frame_start_d;

    logic [15:0] word_h;
    logic [31:0] word_l;
    logic [47:0] word;
    l_src_e      l_src;

    logic            slot_end;
    logic            frame_end;
    logic [NDIG-1:0] blank;
    logic            zero_run;
    logic [3:0]      cur_nib;
    logic            cur_dp;
    logic            cur_blank;
    logic            anode_on;
    logic [7:0]      dec_seg;

    // Compose the 48-bit display word from the page-selected register slices.
    always_comb begin
        unique case (disp_ctrl[CtrlHLsb +: 2])
            2'd0:    word_h = disp_reg[15:0];
            2'd1:    word_h = disp_reg[31:16];
            2'd2:    word_h = disp_reg[47:32];
            default: word_h = disp_reg[63:48];
        endcase
        l_src = l_src_e'(disp_ctrl[CtrlLLsb +: 2]);
        unique case (l_src)
            LSrcMid:  word_l = disp_reg[127:96];
            LSrcLow:  word_l = disp_reg[95:64];
            LSrcTop:  word_l = disp_reg[159:128];
            default:  word_l = 32'h0;
        endcase
        word = {word_h, word_l};
    end

    // Slot counter, digit index and frame snapshot next-state.
    always_comb begin
        slot_end  = &cnt_q;
        frame_end = slot_end && (idx_q == IdxLast);
        cnt_d     = cnt_q + DIV_W'(1);
        idx_d     = idx_q;
        if (slot_end) begin
            idx_d = (idx_q == IdxLast) ? '0 : idx_q + IdxW'(1);
        end
        snap_w_d    = snap_w_q;
        snap_dp_d   = snap_dp_q;
        snap_lz_d   = snap_lz_q;
        // Every edge out of reset consumes the pending load, so it simply clears.
        load_pend_d = 1'b0;
        if (frame_end || load_pend_q) begin
            snap_w_d  = word[WordW-1:0];
            snap_dp_d = dp_mask;
            snap_lz_d = blank_lz;
        end
    end

    // Leading-zero mask: walk down from the top digit while digits stay empty.
    always_comb begin
        zero_run = snap_lz_q;
        blank    = '0;
        for (int i = int'(NDIG) - 1; i >= 0; i--) begin
            zero_run = zero_run & (snap_w_q[4*i +: 4] == 4'h0) & ~snap_dp_q[i];
            blank[i] = (i > 0) ? zero_run : 1'b0;
        end
    end

    // Pick the current digit's nibble, decimal point and blank flag.
    always_comb begin
        cur_nib   = 4'h0;
        cur_dp    = 1'b0;
        cur_blank = 1'b0;
        for (int i = 0; i < int'(NDIG); i++) begin
            if (idx_q == IdxW'(i)) begin
                cur_nib   = snap_w_q[4*i +: 4];
                cur_dp    = snap_dp_q[i];
                cur_blank = blank[i];
            end
        end
    end

    seg7_dec u_seg7_dec (
        .nib_i (cur_nib),
        .dp_i  (cur_dp),
        .seg_o (dec_seg)
    );

    // Output next-state: dead time, PWM window and blanking gate the anode.
    always_comb begin
        anode_on = (cnt_q >= DeadCnt) && (cnt_q[DIV_W-1 -: 4] <= bright) && !cur_blank;
        anode_d  = '1;
        seg_d    = 8'hFF;
        if (anode_on) begin
            anode_d = ~(NDIG'(1) << idx_q);
            seg_d   = dec_seg;
        end
        frame_start_d = (cnt_q == '0) && (idx_q == '0);
    end

    // State and output registers; reset forces blank outputs immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q         <= '0;
            idx_q         <= '0;
            snap_w_q      <= '0;
            snap_dp_q     <= '0;
            snap_lz_q     <= 1'b0;
            load_pend_q   <= 1'b1;
            anode_q       <= '1;
            seg_q         <= 8'hFF;
            frame_start_q <= 1'b0;
        end else begin
            cnt_q         <= cnt_d;
            idx_q         <= idx_d;
            snap_w_q      <= snap_w_d;
            snap_dp_q     <= snap_dp_d;
            snap_lz_q     <= snap_lz_d;
            load_pend_q   <= load_pend_d;
            anode_q       <= anode_d;
            seg_q         <= seg_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign digit_anode = anode_q;
    assign segment     = seg_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_disp_scan_mux.sv
// Directed bench: a 4-digit scanner for the main scenarios and a 12-digit
// one for page selection, both with 32-clock slots and one dead clock.
module tb_disp_scan_mux;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [159:0] disp_reg;
    logic [3:0]   disp_ctrl;
    logic [3:0]   dp_mask;
    logic         blank_lz;
    logic [3:0]   bright;
    logic [3:0]   an4;
    logic [7:0]   seg4;
    logic         fs4;

    logic [159:0] disp_reg12;
    logic [3:0]   disp_ctrl12;
    logic [11:0]  an12;
    logic [7:0]   seg12;
    logic         fs12;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    disp_scan_mux #(.NDIG(4), .DIV_W(5), .DEAD(1)) u_dut4 (
        .clk         (clk),
        .rst         (rst),
        .disp_reg    (disp_reg),
        .disp_ctrl   (disp_ctrl),
        .dp_mask     (dp_mask),
        .blank_lz    (blank_lz),
        .bright      (bright),
        .digit_anode (an4),
        .segment     (seg4),
        .frame_start (fs4)
    );

    disp_scan_mux #(.NDIG(12), .DIV_W(5), .DEAD(1)) u_dut12 (
        .clk         (clk),
        .rst         (rst),
        .disp_reg    (disp_reg12),
        .disp_ctrl   (disp_ctrl12),
        .dp_mask     (12'h000),
        .blank_lz    (1'b0),
        .bright      (4'hF),
        .digit_anode (an12),
        .segment     (seg12),
        .frame_start (fs12)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called right after the dead-clock output of a slot; walks the 32 outputs
    // that follow (cnt 1..31 of this slot, then cnt 0 of the next).
    task automatic measure(input bit big, input logic [11:0] exp_an, input logic [7:0] exp_seg,
                           input int exp_low, input int exp_fs, input string tag);
        int low, other, fs_n, first;
        logic [11:0] obs_an;
        logic [7:0]  obs_seg;
        low = 0; other = 0; fs_n = 0; first = 0;
        for (int j = 1; j <= 32; j++) begin
            tick();
            obs_an  = big ? an12 : {8'hFF, an4};
            obs_seg = big ? seg12 : seg4;
            fs_n   += big ? int'(fs12) : int'(fs4);
            if (obs_an === exp_an && obs_seg === exp_seg) begin
                low++;
                if (first == 0) first = j;
            end else if (!(obs_an === 12'hFFF && obs_seg === 8'hFF)) begin
                other++;
            end
        end
        check({tag, " low"}, low, exp_low);
        check({tag, " other"}, other, 0);
        check({tag, " fs"}, fs_n, exp_fs);
        check({tag, " first"}, first, (exp_low > 0) ? 1 : 0);
    endtask

    initial begin
        disp_reg          = '0;
        disp_reg[127:96]  = 32'h0000_1234;
        disp_ctrl         = 4'h0;
        dp_mask           = 4'b0000;
        blank_lz          = 1'b0;
        bright            = 4'hF;
        disp_reg12        = '0;
        disp_reg12[31:16] = 16'hABCD;
        disp_ctrl12       = 4'b0111;

        // Held in reset
        repeat (3) tick();
        check("rst an", an4, 4'hF);
        check("rst seg", seg4, 8'hFF);
        check("rst fs", fs4, 1'b0);
        check("rst an12", an12, 12'hFFF);

        @(negedge clk);
        rst = 1'b0;
        tick();
        check("e0 fs", fs4, 1'b1);
        check("e0 an", an4, 4'hF);
        check("e0 seg", seg4, 8'hFF);

        // Frame 1: 1234 at full brightness
        measure(1'b0, 12'hFFE, 8'h99, 31, 0, "f1 d0");
        measure(1'b0, 12'hFFD, 8'hB0, 31, 0, "f1 d1");
        measure(1'b0, 12'hFFB, 8'hA4, 31, 0, "f1 d2");
        measure(1'b0, 12'hFF7, 8'hF9, 31, 1, "f1 d3");

        // Frame 2: value changes during slot 1 but the frame keeps 1234
        measure(1'b0, 12'hFFE, 8'h99, 31, 0, "f2 d0");
        disp_reg[127:96] = 32'h0000_5678;
        measure(1'b0, 12'hFFD, 8'hB0, 31, 0, "f2 d1");
        measure(1'b0, 12'hFFB, 8'hA4, 31, 0, "f2 d2");
        measure(1'b0, 12'hFF7, 8'hF9, 31, 1, "f2 d3");

        // Frame 3: 5678, brightness 0 then 7
        bright = 4'h0;
        measure(1'b0, 12'hFFE, 8'h80, 1, 0, "f3 d0 br0");
        measure(1'b0, 12'hFFD, 8'hF8, 1, 0, "f3 d1 br0");
        bright = 4'h7;
        measure(1'b0, 12'hFFB, 8'h82, 15, 0, "f3 d2 br7");
        measure(1'b0, 12'hFF7, 8'h92, 15, 1, "f3 d3 br7");

        // Frame 4: new value and LZ enable only land at the next frame
        bright           = 4'hF;
        disp_reg[127:96] = 32'h0000_0007;
        blank_lz         = 1'b1;
        measure(1'b0, 12'hFFE, 8'h80, 31, 0, "f4 d0");
        measure(1'b0, 12'hFFD, 8'hF8, 31, 0, "f4 d1");
        measure(1'b0, 12'hFFB, 8'h82, 31, 0, "f4 d2");
        measure(1'b0, 12'hFF7, 8'h92, 31, 1, "f4 d3");

        // Frame 5: 0007 with leading-zero blanking
        measure(1'b0, 12'hFFE, 8'hF8, 31, 0, "f5 d0");
        dp_mask = 4'b0100;
        measure(1'b0, 12'hFFD, 8'hFF, 0, 0, "f5 d1 blank");
        measure(1'b0, 12'hFFB, 8'hFF, 0, 0, "f5 d2 blank");
        measure(1'b0, 12'hFF7, 8'hFF, 0, 1, "f5 d3 blank");

        // Frame 6: decimal point on digit 2 stops blanking at and below it
        measure(1'b0, 12'hFFE, 8'hF8, 31, 0, "f6 d0");
        measure(1'b0, 12'hFFD, 8'hC0, 31, 0, "f6 d1");
        measure(1'b0, 12'hFFB, 8'h40, 31, 0, "f6 d2 dp");
        measure(1'b0, 12'hFF7, 8'hFF, 0, 1, "f6 d3 blank");

        // Asynchronous reset while digit 0 is lit
        repeat (5) tick();
        check("pre-rst an", an4, 4'hE);
        check("pre-rst seg", seg4, 8'hF8);
        rst = 1'b1;
        #1;
        check("async an", an4, 4'hF);
        check("async seg", seg4, 8'hFF);
        check("async an12", an12, 12'hFFF);
        @(negedge clk);
        rst = 1'b0;
        tick();
        check("re e0 fs", fs4, 1'b1);
        check("re e0 fs12", fs12, 1'b1);
        tick();
        check("re e1 an", an4, 4'hE);
        check("re e1 seg", seg4, 8'hF8);
        check("re e1 an12", an12, 12'hFFE);
        check("re e1 seg12", seg12, 8'hC0);
        repeat (31) tick();

        // 12-digit page select: ABCD on digits 11..8, zeros below
        for (int d = 1; d < 8; d++) begin
            measure(1'b1, ~(12'h001 << d), 8'hC0, 31, 0, "pg low");
        end
        measure(1'b1, 12'hEFF, 8'hA1, 31, 0, "pg d8");
        measure(1'b1, 12'hDFF, 8'hC6, 31, 0, "pg d9");
        measure(1'b1, 12'hBFF, 8'h83, 31, 0, "pg d10");
        measure(1'b1, 12'h7FF, 8'h88, 31, 1, "pg d11");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/disp_scan_mux.md
# disp_scan_mux

Parametrised time-multiplexed 7-segment scanner for the board's common-anode display bank, sitting between the debug register file and the anode/segment pins. It composes the displayed value from the 160-bit register bus under `disp_ctrl`. It scans a configurable number of digits with a programmable slot length and per-slot brightness PWM, and inserts a dead-time blank at each digit change to suppress ghosting. It snapshots the display data once per frame so a value never tears mid-scan, and it supports decimal points and leading-zero blanking.

## Interface
Parameters:
- `NDIG`, 12: number of digits scanned, 1..12.
- `DIV_W`, 9: slot counter width; each digit slot is 2^DIV_W clocks. Must be ≥5.
- `DEAD`, 2: clocks of forced blank at the start of each slot. Must satisfy 1 ≤ DEAD < 2^(DIV_W-4).

Ports:
- `clk`, in, 1: the single clock.
- `rst`, in, 1: reset, asynchronous, active-high.
- `disp_reg`, in, 160: register-file bus.
- `disp_ctrl`, in, 4: page select.
- `dp_mask`, in, NDIG: decimal-point enable per digit; bit i maps to digit i.
- `blank_lz`, in, 1: enables leading-zero blanking.
- `bright`, in, 4: brightness; 0 is the dimmest, 15 is full.
- `digit_anode`, out, NDIG: active-low digit enables.
- `segment`, out, 8: active-low segments ordered {dp,g,f,e,d,c,b,a}.
- `frame_start`, out, 1: one-clock pulse when digit 0's slot begins.

## Operation
- Composed word W[47:0] = {H, L}.
  - H = `disp_reg[16*disp_ctrl[3:2] +: 16]`.
  - L is selected by `disp_ctrl[1:0]`: 0 gives `disp_reg[127:96]`, 1 gives `[95:64]`, 2 gives `[159:128]`, 3 gives 32'h0.
  - Digit i displays W[4i+3:4i], i < NDIG. Bits above 4*NDIG are ignored.
- Counters:
  - `cnt` (DIV_W bits) increments every clock.
  - `idx` (0..NDIG-1) advances when `cnt` is all-ones, wrapping NDIG-1 → 0.
  - For NDIG=1, `idx` stays at 0.
- Snapshot:
  - W[4*NDIG-1:0], `dp_mask` and `blank_lz` are captured into frame registers on the edge where `cnt` is all-ones and `idx` = NDIG-1.
  - They are also captured on the first clock edge after `rst` deasserts, via a `load_pend` flag that reset sets and the first load clears.
  - Input changes at any other time have no visible effect until the next frame.
- Leading-zero mask, computed from the snapshot:
  - Digit i is blanked iff `blank_lz`=1, i > 0, and every digit j with i ≤ j < NDIG has nibble 0 and dp bit 0.
  - Digit 0 is never blanked.
- Anode for the current digit is driven low iff all of the following hold; otherwise all anodes are high:
  - `cnt` ≥ DEAD,
  - q ≤ `bright`, where q = `cnt[DIV_W-1:DIV_W-4]`,
  - the digit is not blanked.
- Segment output:
  - segment[6:0] is the hex decode of the snapshot nibble: 0:C0 1:F9 2:A4 3:B0 4:99 5:92 6:82 7:F8 8:80 9:90 A:88 B:83 C:C6 D:A1 E:86 F:8E (8-bit values with dp=1).
  - segment[7] = ~dp.
  - segment = 8'hFF whenever the anode is off.

## Timing
- Reset values:
  - `digit_anode` = all ones.
  - `segment` = 8'hFF.
  - `frame_start` = 0.
  - `cnt` = 0, `idx` = 0.
  - Snapshot = 0; `load_pend` = 1.
- All outputs are registered with one-clock latency. Outputs in cycle t+1 reflect `cnt`/`idx`/snapshot in cycle t.
- Slot timing:
  - The first anode-low clock of a slot is DEAD+1 clocks after `cnt` wraps to 0.
  - At `bright`=15 the anode stays low to slot end, with 2^DIV_W − DEAD low clocks per slot.
- `frame_start` is high in the cycle after `cnt`=0 and `idx`=0 are present (aligned to the outputs). It first occurs on the first clock after reset release.
- The snapshot edge and the `idx` wrap happen on the same edge; the new frame's digit 0 uses the new snapshot.
- Reset mid-slot forces outputs to their reset values immediately, without waiting for a clock. The scan restarts at digit 0 with a fresh snapshot.

## Structure
- Package `disp_pkg` holds:
  - the 16-entry segment decode constant,
  - the `disp_ctrl` field positions and L-source encodings,
  - the digit-count limit (12).
- Sub-module `seg7_dec`: combinational nibble+dp → 8-bit active-low segments. It is instantiated once, on the current digit's snapshot nibble.
- The counters, snapshot, LZ mask, PWM compare and output registers live in the top.

## Test plan
All scenarios use NDIG=4, DIV_W=5, DEAD=1 unless stated.
- Reset and first frame:
  - Stimulus: `rst` pulse; `disp_reg[127:96]`=32'h0000_1234; `disp_ctrl`=0; `bright`=15.
  - Required: anodes 1111/`segment` FF during reset. Slot 0 shows `segment` 99 (digit "4") with `digit_anode`=1110 for 31 clocks, after 1 dead clock plus 1 latency clock. Then B0, A4, F9 on anodes 1101, 1011, 0111. `frame_start` pulses once per 128 clocks.
- Tear-free snapshot:
  - Stimulus: change `disp_reg` to 32'h0000_5678 during slot 1.
  - Required: the current frame still shows 1234; the next frame shows 5678.
- Brightness:
  - Stimulus: `bright`=0.
  - Required: anode low for exactly cnt 1 only, i.e. 1 clock per slot.
  - Stimulus: `bright`=7.
  - Required: 15 low clocks per slot.
- Leading-zero blanking:
  - Stimulus: value 0x0007, `blank_lz`=1.
  - Required: digits 3..1 keep their anodes high and `segment` FF; digit 0 shows F8.
  - Stimulus: same, with `dp_mask`=0100.
  - Required: digit 2 shows 40 (decode C0 with dp), digit 1 shows C0, digit 3 is blank.
- Page select:
  - Stimulus: `disp_ctrl`=4'b0111 with `disp_reg[31:16]`=16'hABCD, under NDIG=12.
  - Required: digits 11..8 show 88, 83, C6, A1; digits 7..0 show C0.
- Async reset mid-slot:
  - Stimulus: assert `rst` while an anode is low.
  - Required: `digit_anode` is all ones within the same delta, without waiting for a `clk` edge; after release the scan restarts at digit 0.
